// File: rtl/imm_gen_if.sv
// imm_gen_if: instruction-in / immediate-out handshake bundle for imm_gen_pipe.
// Illegal-opcode signals exist only when IMMGEN_ILLEGAL_EN is defined.
interface imm_gen_if #(
    parameter int IMM_W = 16
`ifdef IMMGEN_ILLEGAL_EN
    , parameter int CNT_W = 16
`endif
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      instruction;
    logic             out_valid;
    logic             out_ready;
    logic [IMM_W-1:0] immediate_out;
    logic [2:0]       imm_class;
`ifdef IMMGEN_ILLEGAL_EN
    logic             out_illegal;
    logic [CNT_W-1:0] illegal_count;
`endif
    modport slave (
        input  in_valid, instruction, out_ready,
        output in_ready, out_valid, immediate_out, imm_class
`ifdef IMMGEN_ILLEGAL_EN
        , output out_illegal, illegal_count
`endif
    );
    modport master (
        output in_valid, instruction, out_ready,
        input  in_ready, out_valid, immediate_out, imm_class
`ifdef IMMGEN_ILLEGAL_EN
        , input out_illegal, illegal_count
`endif
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate generator with registered output and one-entry skid buffer.
// Optional illegal-opcode flag and saturating counter enabled by IMMGEN_ILLEGAL_EN.
module imm_gen_pipe #(
    parameter int IMM_W = 16,
    parameter bit SEXT  = 1,
    parameter int CNT_W = 16
) (
    input logic     clk,
    input logic     rst_n,
    imm_gen_if.slave bus
);
    if (IMM_W < 9 || IMM_W > 32 || CNT_W < 1) begin : g_bad
        $error("imm_gen_pipe: IMM_W must be 9..32 and CNT_W >= 1");
    end

    typedef struct packed {
        logic [IMM_W-1:0] imm;
        logic [2:0]       cls;
`ifdef IMMGEN_ILLEGAL_EN
        logic             ill;
`endif
    } ent_t;

    // fill marks raw bits above the field width; they take the extension bit like the upper bits
    function automatic logic [IMM_W-1:0] ext(input logic [8:0] raw, input logic [8:0] fill, input logic s);
        logic [IMM_W-1:0] r;
        r = {IMM_W{s}};
        r[8:0] = (raw & ~fill) | ({9{s}} & fill);
        return r;
    endfunction

    logic [3:0] op, p1, p2, p3;
    ent_t       d, o, sk;
    logic       ov, sv, rdy, in_fire, free;

    assign op = bus.instruction[3:0];
    assign p1 = bus.instruction[7:4];
    assign p2 = bus.instruction[11:8];
    assign p3 = bus.instruction[15:12];

    always_comb begin
        d     = '0;
        case (op[2:0])
            3'b001: begin d.cls = 3'd1; d.imm = ext({5'b0, p3}, 9'h1F0, SEXT & p3[3]); end
            3'b010: begin d.cls = 3'd2; d.imm = ext({4'b0, p1, op[3]}, 9'h1E0, SEXT & p1[3]); end
            3'b011: begin d.cls = 3'd3; d.imm = ext({5'b0, p1}, 9'h1F0, SEXT & p1[3]); end
            3'b100: begin d.cls = 3'd4; d.imm = ext({op[3], p3, p2}, 9'h000, SEXT & op[3]); end
            default: ;
        endcase
`ifdef IMMGEN_ILLEGAL_EN
        d.ill = op[2] & (op[1] | op[0]);
`endif
    end

    assign in_fire = bus.in_valid & rdy;
    assign free    = ~ov | bus.out_ready;

    // rdy mirrors ~sv but is its own flop so in_ready has no logic in front of it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov  <= 1'b0;
            sv  <= 1'b0;
            rdy <= 1'b1;
            o   <= '0;
            sk  <= '0;
        end else if (free) begin
            if (sv) begin
                o   <= sk;
                sv  <= 1'b0;
                rdy <= 1'b1;
            end else if (in_fire) begin
                o   <= d;
                ov  <= 1'b1;
            end else begin
                ov  <= 1'b0;
            end
        end else if (in_fire) begin
            sk  <= d;
            sv  <= 1'b1;
            rdy <= 1'b0;
        end
    end

    assign bus.in_ready      = rdy;
    assign bus.out_valid     = ov;
    assign bus.immediate_out = o.imm;
    assign bus.imm_class     = o.cls;

`ifdef IMMGEN_ILLEGAL_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (ov && bus.out_ready && o.ill && !(&cnt))
            cnt <= cnt + 1'b1;
    end

    assign bus.out_illegal   = o.ill;
    assign bus.illegal_count = cnt;
`endif
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed vectors against a 16-bit sign-extending and a 32-bit zero-extending instance.
module tb_imm_gen_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    imm_gen_if #(.IMM_W(16)
`ifdef IMMGEN_ILLEGAL_EN
        , .CNT_W(16)
`endif
    ) b0 ();
    imm_gen_if #(.IMM_W(32)
`ifdef IMMGEN_ILLEGAL_EN
        , .CNT_W(2)
`endif
    ) b1 ();

    imm_gen_pipe #(.IMM_W(16), .SEXT(1), .CNT_W(16)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    imm_gen_pipe #(.IMM_W(32), .SEXT(0), .CNT_W(2))  u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    typedef struct {
        logic [15:0] ins;
        logic [15:0] e16;
        logic [31:0] e32;
        logic [2:0]  cls;
        logic        ill;
    } vec_t;

    vec_t v[16];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [15:0] ins, input logic ordy);
        b0.in_valid = vld; b0.instruction = ins; b0.out_ready = ordy;
        b1.in_valid = vld; b1.instruction = ins; b1.out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string n, input logic ov, input logic [15:0] e16, input logic [31:0] e32, input logic [2:0] cls);
        chk({n, ".valid16"}, b0.out_valid, ov);
        chk({n, ".valid32"}, b1.out_valid, ov);
        chk({n, ".imm16"}, b0.immediate_out, e16);
        chk({n, ".imm32"}, b1.immediate_out, e32);
        chk({n, ".cls16"}, b0.imm_class, cls);
        chk({n, ".cls32"}, b1.imm_class, cls);
    endtask

    initial begin
        v[0]  = '{16'hF001, 16'hFFFF, 32'h0000000F, 3'd1, 1'b0};
        v[1]  = '{16'h007A, 16'h000F, 32'h0000000F, 3'd2, 1'b0};
        v[2]  = '{16'h0053, 16'h0005, 32'h00000005, 3'd3, 1'b0};
        v[3]  = '{16'h8A0C, 16'hFF8A, 32'h0000018A, 3'd4, 1'b0};
        v[4]  = '{16'h0000, 16'h0000, 32'h00000000, 3'd0, 1'b0};
        v[5]  = '{16'h0081, 16'h0000, 32'h00000000, 3'd1, 1'b0};
        v[6]  = '{16'h7009, 16'h0007, 32'h00000007, 3'd1, 1'b0};
        v[7]  = '{16'h00F2, 16'hFFFE, 32'h0000001E, 3'd2, 1'b0};
        v[8]  = '{16'h00FB, 16'hFFFF, 32'h0000000F, 3'd3, 1'b0};
        v[9]  = '{16'h0004, 16'h0000, 32'h00000000, 3'd4, 1'b0};
        v[10] = '{16'h0405, 16'h0000, 32'h00000000, 3'd0, 1'b1};
        v[11] = '{16'h123F, 16'h0000, 32'h00000000, 3'd0, 1'b1};
        v[12] = '{16'hFF0E, 16'h0000, 32'h00000000, 3'd0, 1'b1};
        v[13] = '{16'h8008, 16'h0000, 32'h00000000, 3'd0, 1'b0};
        v[14] = '{16'h0F04, 16'h000F, 32'h0000000F, 3'd4, 1'b0};
        v[15] = '{16'hF00C, 16'hFFF0, 32'h000001F0, 3'd4, 1'b0};

        drive(1'b0, 16'h0000, 1'b0);
        #1 rst_n = 1'b0;
        #10;
        chk_out("reset", 1'b0, 16'h0, 32'h0, 3'd0);
        chk("reset.in_ready", b0.in_ready, 1'b1);
        rst_n = 1'b1;
        step();

        // streaming at full rate: each step shows the previous cycle's input
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, v[i].ins, 1'b1);
            step();
            chk_out($sformatf("vec%0d", i), 1'b1, v[i].e16, v[i].e32, v[i].cls);
            chk($sformatf("vec%0d.in_ready", i), b0.in_ready, 1'b1);
`ifdef IMMGEN_ILLEGAL_EN
            chk($sformatf("vec%0d.ill16", i), b0.out_illegal, v[i].ill);
            chk($sformatf("vec%0d.ill32", i), b1.out_illegal, v[i].ill);
`endif
        end
        drive(1'b0, 16'h0000, 1'b1);
        step();
        chk("drain.valid", b0.out_valid, 1'b0);
`ifdef IMMGEN_ILLEGAL_EN
        chk("table.count16", b0.illegal_count, 16'd3);
        chk("table.count2", b1.illegal_count, 2'd3);
`endif

        // stall with skid fill, then drain in order
        drive(1'b1, 16'h1001, 1'b0);
        step();
        chk_out("stall1", 1'b1, 16'h1, 32'h1, 3'd1);
        chk("stall1.in_ready", b0.in_ready, 1'b1);
        drive(1'b1, 16'h2001, 1'b0);
        step();
        chk_out("stall2", 1'b1, 16'h1, 32'h1, 3'd1);
        chk("stall2.in_ready", b0.in_ready, 1'b0);
        drive(1'b1, 16'h3001, 1'b0);
        step();
        chk_out("stall3", 1'b1, 16'h1, 32'h1, 3'd1);
        chk("stall3.in_ready", b1.in_ready, 1'b0);
        drive(1'b1, 16'h3001, 1'b1);
        step();
        chk_out("drain2", 1'b1, 16'h2, 32'h2, 3'd1);
        chk("drain2.in_ready", b0.in_ready, 1'b1);
        step();
        chk_out("drain3", 1'b1, 16'h3, 32'h3, 3'd1);
        drive(1'b0, 16'h0000, 1'b1);
        step();
        chk("drain_end.valid", b0.out_valid, 1'b0);
        chk("drain_end.valid32", b1.out_valid, 1'b0);

        // asynchronous reset with both entries occupied
        drive(1'b1, 16'h1001, 1'b0);
        step();
        drive(1'b1, 16'h2001, 1'b0);
        step();
        drive(1'b0, 16'h0000, 1'b0);
        chk("full.in_ready", b0.in_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_out("midrst", 1'b0, 16'h0, 32'h0, 3'd0);
        chk("midrst.in_ready", b0.in_ready, 1'b1);
        chk("midrst.in_ready32", b1.in_ready, 1'b1);
        #2 rst_n = 1'b1;
        drive(1'b0, 16'h0000, 1'b1);
        step();
        step();
        chk("postrst.valid", b0.out_valid, 1'b0);
        chk("postrst.valid32", b1.out_valid, 1'b0);
        chk("postrst.in_ready", b0.in_ready, 1'b1);

`ifdef IMMGEN_ILLEGAL_EN
        chk("postrst.count16", b0.illegal_count, 16'd0);
        chk("postrst.count2", b1.illegal_count, 2'd0);
        for (int j = 1; j <= 5; j++) begin
            drive(1'b1, 16'h0007, 1'b1);
            step();
            chk($sformatf("ill%0d.flag", j), b0.out_illegal, 1'b1);
            chk($sformatf("ill%0d.cls", j), b0.imm_class, 3'd0);
            chk($sformatf("ill%0d.count16", j), b0.illegal_count, 16'(j - 1));
            if (j == 4) chk("ill4.count2", b1.illegal_count, 2'd3);
        end
        drive(1'b0, 16'h0000, 1'b1);
        step();
        chk("ill.count16", b0.illegal_count, 16'd5);
        chk("ill.count2_sat", b1.illegal_count, 2'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
